tt_um_serial_adder_ctrl: RTL and testbench

TT_UM_SERIAL_ADDER_CTRL -- requirements
Module: tt_um_serial_adder_ctrl

---
 rtl/tt_um_serial_adder_ctrl_pkg.sv | 20 ++
 rtl/fa_bit.sv | 30 +++
 rtl/ha.sv | 12 +
 rtl/tt_um_serial_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_tt_um_serial_adder_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_um_serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding,
// operand width and output bit positions.
package tt_um_serial_adder_ctrl_pkg;

    localparam int unsigned OpWidth  = 4;
    localparam int unsigned SumWidth = OpWidth + 1;

    // uo_out bit positions
    localparam int unsigned OutCarry = 4;
    localparam int unsigned OutBusy  = 5;
    localparam int unsigned OutDone  = 6;
    localparam int unsigned OutOvf   = 7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/fa_bit.sv
// Single-bit full adder built from two half adders and an OR of their carries.
module fa_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    ha u_ha0 (
        .i_a (i_a),
        .i_b (i_b),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    ha u_ha1 (
        .i_a (w_s0),
        .i_b (i_cin),
        .o_s (o_sum),
        .o_c (w_c1)
    );

    assign o_cout = w_c0 | w_c1;

endmodule

// File: rtl/ha.sv
// Half adder cell.
module ha (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;

endmodule

// File: rtl/tt_um_serial_adder_ctrl.sv
// Bit-serial 4+4 bit unsigned adder: one full-adder cell stepped LSB first,
// one bit every STEP_DIV enabled cycles, result latched on completion.
module tt_um_serial_adder_ctrl
    import tt_um_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned STEP_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] StepLast = 8'(STEP_DIV - 1);
    localparam logic [1:0] BitLast  = 2'(OpWidth - 1);

    state_e               r_state, w_state_nxt;
    logic                 r_start_q, w_start_q_nxt;
    logic                 r_armed, w_armed_nxt;
    logic [OpWidth-1:0]   r_a, w_a_nxt;
    logic [OpWidth-1:0]   r_b, w_b_nxt;
    logic                 r_carry, w_carry_nxt;
    logic [OpWidth-1:0]   r_psum, w_psum_nxt;
    logic [1:0]           r_bit_idx, w_bit_idx_nxt;
    logic [7:0]           r_step_cnt, w_step_cnt_nxt;
    logic [SumWidth-1:0]  r_sum, w_sum_nxt;
    logic                 r_ovf, w_ovf_nxt;

    logic                 w_start_edge;
    logic                 w_fa_sum;
    logic                 w_fa_cout;
    logic [OpWidth-1:0]   w_psum_shift;
    logic                 w_unused;

    fa_bit u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // r_armed blocks a start that was already high when reset released.
    assign w_start_edge = uio_in[0] & ~r_start_q & r_armed;
    assign w_psum_shift = {w_fa_sum, r_psum[OpWidth-1:1]};
    assign w_unused     = ^uio_in[7:1];

    always_comb begin
        w_state_nxt    = r_state;
        w_start_q_nxt  = r_start_q;
        w_armed_nxt    = r_armed;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_carry_nxt    = r_carry;
        w_psum_nxt     = r_psum;
        w_bit_idx_nxt  = r_bit_idx;
        w_step_cnt_nxt = r_step_cnt;
        w_sum_nxt      = r_sum;
        w_ovf_nxt      = r_ovf;

        if (ena) begin
            w_start_q_nxt = uio_in[0];
            w_armed_nxt   = r_armed | ~uio_in[0];

            unique case (r_state)
                StIdle, StDone: begin
                    if (w_start_edge) begin
                        w_a_nxt        = ui_in[3:0];
                        w_b_nxt        = ui_in[7:4];
                        w_carry_nxt    = 1'b0;
                        w_psum_nxt     = '0;
                        w_bit_idx_nxt  = '0;
                        w_step_cnt_nxt = '0;
                        w_state_nxt    = StAdd;
                    end
                end
                StAdd: begin
                    if (r_step_cnt == StepLast) begin
                        w_step_cnt_nxt = '0;
                        w_psum_nxt     = w_psum_shift;
                        w_a_nxt        = {1'b0, r_a[OpWidth-1:1]};
                        w_b_nxt        = {1'b0, r_b[OpWidth-1:1]};
                        w_carry_nxt    = w_fa_cout;
                        w_bit_idx_nxt  = r_bit_idx + 2'd1;
                        if (r_bit_idx == BitLast) begin
                            w_sum_nxt   = {w_fa_cout, w_psum_shift};
                            w_ovf_nxt   = w_fa_cout;
                            w_state_nxt = StDone;
                        end
                    end else begin
                        w_step_cnt_nxt = r_step_cnt + 8'd1;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_start_q  <= 1'b0;
            r_armed    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_psum     <= '0;
            r_bit_idx  <= '0;
            r_step_cnt <= '0;
            r_sum      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_start_q  <= w_start_q_nxt;
            r_armed    <= w_armed_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_carry    <= w_carry_nxt;
            r_psum     <= w_psum_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_step_cnt <= w_step_cnt_nxt;
            r_sum      <= w_sum_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    always_comb begin
        uo_out                = '0;
        uo_out[OutCarry:0]    = r_sum;
        uo_out[OutBusy]       = (r_state == StAdd);
        uo_out[OutDone]       = (r_state == StDone);
        uo_out[OutOvf]        = r_ovf;
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_serial_adder_ctrl.sv
// Self-checking bench: STEP_DIV=1 and STEP_DIV=3 instances on shared inputs,
// table vectors, random and exhaustive sweeps against an arithmetic model.
module tb_tt_um_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out1, uio_out1, uio_oe1;
    logic [7:0] uo_out3, uio_out3, uio_oe3;

    int n_checks;
    int n_fail;
    logic [7:0] prev1;
    logic [7:0] prev3;

    tt_um_serial_adder_ctrl #(.STEP_DIV(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out1),
        .uio_out (uio_out1),
        .uio_oe  (uio_oe1)
    );

    tt_um_serial_adder_ctrl #(.STEP_DIV(3)) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out3),
        .uio_out (uio_out3),
        .uio_oe  (uio_oe3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_out(input int sel);
        return (sel == 3) ? uo_out3 : uo_out1;
    endfunction

    // Reference: completed result = plain 5-bit sum, overflow when > 15, done set.
    function automatic logic [7:0] ref_out(input logic [3:0] a, input logic [3:0] b);
        int s;
        logic [7:0] r;
        s = int'(a) + int'(b);
        r = 8'(s);
        r[7] = (s > 15);
        r[6] = 1'b1;
        r[5] = 1'b0;
        return r;
    endfunction

    task automatic run_add(input int sel, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp, input string tag);
        logic [7:0] o;
        logic [7:0] prev;
        int cyc;
        prev = (sel == 3) ? prev3 : prev1;
        ui_in  = {b, a};
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
        o = get_out(sel);
        check({tag, " busy/done at capture"}, 32'(o[6:5]), 32'h1);
        check({tag, " result held during add"}, 32'(o & 8'h9F), 32'(prev));
        cyc = 0;
        while (!o[6] && cyc < 200) begin
            tick();
            cyc++;
            o = get_out(sel);
        end
        check({tag, " latency"}, 32'(cyc), 32'(4 * sel));
        check({tag, " result"}, 32'(o), 32'(exp));
        if (sel == 3) prev3 = exp & 8'h9F;
        else          prev1 = exp & 8'h9F;
    endtask

    initial begin
        logic [7:0] o;
        logic [7:0] exp;
        logic [3:0] ra, rb;
        int cyc, done_rises, busy_rises;
        logic last_done, last_busy;

        n_checks = 0;
        n_fail   = 0;
        prev1    = 8'h00;
        prev3    = 8'h00;

        vecs[0] = '{a: 4'd3,  b: 4'd5,  exp_out: 8'h48};
        vecs[1] = '{a: 4'd15, b: 4'd15, exp_out: 8'hDE};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  exp_out: 8'h40};
        vecs[3] = '{a: 4'd6,  b: 4'd10, exp_out: 8'hD0};
        vecs[4] = '{a: 4'd9,  b: 4'd7,  exp_out: 8'hD0};
        vecs[5] = '{a: 4'd1,  b: 4'd2,  exp_out: 8'h43};
        vecs[6] = '{a: 4'd15, b: 4'd0,  exp_out: 8'h4F};
        vecs[7] = '{a: 4'd8,  b: 4'd8,  exp_out: 8'hD0};
        vecs[8] = '{a: 4'd12, b: 4'd5,  exp_out: 8'hD1};

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tick();
        tick();
        check("reset uo_out div1", 32'(uo_out1), 32'h0);
        check("reset uo_out div3", 32'(uo_out3), 32'h0);
        check("uio_out const", 32'(uio_out1), 32'h0);
        check("uio_oe const", 32'(uio_oe1), 32'h0);
        rst_n = 1'b1;
        tick();

        // 3+5, then 15+15 followed by restart from DONE with 0+0
        run_add(1, 4'd3, 4'd5, 8'h48, "3+5");
        run_add(1, 4'd15, 4'd15, 8'hDE, "15+15");
        run_add(1, 4'd0, 4'd0, 8'h40, "restart 0+0");

        // Level-held start: exactly one computation
        ui_in  = {4'd3, 4'd2};
        uio_in = 8'h01;
        o = uo_out1;
        last_done = o[6];
        last_busy = o[5];
        done_rises = 0;
        busy_rises = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            o = uo_out1;
            if (o[6] && !last_done) done_rises++;
            if (o[5] && !last_busy) busy_rises++;
            last_done = o[6];
            last_busy = o[5];
        end
        check("held start busy rises", 32'(busy_rises), 32'd1);
        check("held start done rises", 32'(done_rises), 32'd1);
        check("held start result", 32'(o), 32'(ref_out(4'd2, 4'd3)));
        uio_in = 8'h00;
        tick();
        prev1 = ref_out(4'd2, 4'd3) & 8'h9F;

        // Second start pulse at ADD cycle 2 is ignored
        ui_in  = {4'd2, 4'd7};
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
        cyc = 0;
        tick();
        cyc++;
        ui_in  = {4'd15, 4'd15};
        uio_in = 8'h01;
        tick();
        cyc++;
        uio_in = 8'h00;
        o = uo_out1;
        while (!o[6] && cyc < 50) begin
            tick();
            cyc++;
            o = uo_out1;
        end
        check("ignored pulse latency", 32'(cyc), 32'd4);
        check("ignored pulse result", 32'(o), 32'(ref_out(4'd7, 4'd2)));
        repeat (3) tick();
        check("ignored pulse no queued restart", 32'(uo_out1), 32'(ref_out(4'd7, 4'd2)));
        prev1 = ref_out(4'd7, 4'd2) & 8'h9F;

        // Reset during 3rd step of 9+7
        ui_in  = {4'd7, 4'd9};
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mid-add reset uo_out", 32'(uo_out1), 32'h0);
        rst_n = 1'b1;
        tick();
        prev1 = 8'h00;
        prev3 = 8'h00;
        run_add(1, 4'd9, 4'd7, 8'hD0, "after reset 9+7");

        // Start already high at reset release does not trigger
        rst_n  = 1'b0;
        uio_in = 8'h01;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("held start after reset no trigger", 32'(uo_out1), 32'h0);
        uio_in = 8'h00;
        tick();
        prev1 = 8'h00;
        run_add(1, 4'd4, 4'd4, ref_out(4'd4, 4'd4), "post-reset rearm");

        // ena low for 5 cycles mid-ADD
        ui_in  = {4'd10, 4'd6};
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
        cyc = 0;
        tick();
        cyc++;
        tick();
        cyc++;
        ena = 1'b0;
        repeat (5) begin
            tick();
            cyc++;
        end
        check("ena freeze busy held", 32'(uo_out1[6:5]), 32'h1);
        ena = 1'b1;
        o = uo_out1;
        while (!o[6] && cyc < 50) begin
            tick();
            cyc++;
            o = uo_out1;
        end
        check("ena freeze latency", 32'(cyc), 32'd9);
        check("ena freeze result", 32'(o), 32'h0D0);
        prev1 = 8'hD0 & 8'h9F;

        for (int i = 0; i < 9; i++)
            run_add(1, vecs[i].a, vecs[i].b, vecs[i].exp_out, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_add(1, ra, rb, ref_out(ra, rb), $sformatf("rand%0d", i));
        end

        // STEP_DIV=3 instance
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        prev1 = 8'h00;
        prev3 = 8'h00;
        run_add(3, 4'd1, 4'd2, 8'h43, "div3 1+2");
        for (int i = 0; i < 256; i++) begin
            ra = 4'(i);
            rb = 4'(i >> 4);
            exp = ref_out(ra, rb);
            run_add(3, ra, rb, exp, $sformatf("sweep a%0d b%0d", ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
